// File: rtl/ex_stage_hs.sv
// ex_stage_hs: DLX execute stage with valid/ready handshake, forwarding, load-use stall, flush, registered branch resolution; optional iterative MUL under EX_MULDIV_EN
module ex_stage_hs #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int IMMW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [5:0]      opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [IMMW-1:0] imm,
  input  logic [REGW-1:0] rs,
  input  logic [REGW-1:0] rt,
  input  logic [REGW-1:0] rd,
  input  logic [1:0]      alusrc,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic            mem_write,
  input  logic            branch,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] store_data,
  output logic [REGW-1:0] rd_o,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            mem_write_o,
  output logic            branch_taken,
  output logic            zero,
  output logic            carry,
  output logic            overflow,
  output logic            set,
  output logic            load_stall,
  output logic            busy
);
  localparam int M = XLEN - 1;
  logic adv, accept, idle, wr_alu, wr_mul, start_mul, add_op, sub_op, slt, ovf, cry, zr, cond, ex_ok, unused;
  logic [XLEN-1:0] op_a, op_b, rt_val, alu_res, imm_z, w_res, w_sd;
  logic [XLEN:0] sum;
  logic [REGW-1:0] w_rd;
  logic w_rw, w_mtr, w_mw;
  assign unused = ^opcode[5:2];
  assign adv = !out_valid | out_ready;
  assign load_stall = in_valid & out_valid & mem_to_reg_o & (rd_o != '0) & ((rd_o == rs) | (rd_o == rt));
  assign in_ready = rst_n & adv & !load_stall & idle;
  assign accept = in_valid & in_ready & !flush;
  assign ex_ok = out_valid & reg_write_o & !mem_to_reg_o;
  assign op_a = (ex_ok & rs != '0 & rd_o == rs) ? result :
                (mem_rd_we & rs != '0 & mem_rd == rs) ? mem_fwd_data : a;
  assign rt_val = (ex_ok & rt != '0 & rd_o == rt) ? result :
                  (mem_rd_we & rt != '0 & mem_rd == rt) ? mem_fwd_data : b;
  assign imm_z = {{(XLEN-IMMW){1'b0}}, imm};
  assign op_b = alusrc == 2'b00 ? rt_val :
                alusrc == 2'b01 ? {{(XLEN-IMMW){imm[IMMW-1]}}, imm} :
                alusrc == 2'b10 ? imm_z : imm_z << 16;
`ifdef EX_MULDIV_EN
  assign add_op = op == 4'b0010;
`else
  assign add_op = op == 4'b0010 || op == 4'b1000;
`endif
  assign sub_op = op == 4'b0110 || op == 4'b0111;
  assign sum = {1'b0, op_a} + {1'b0, sub_op ? ~op_b : op_b} + {{XLEN{1'b0}}, sub_op};
  // SLT takes the sign of a-b corrected by its signed overflow
  assign slt = sum[M] ^ ((op_a[M] != op_b[M]) & (sum[M] != op_a[M]));
  assign ovf = add_op ? (op_a[M] == op_b[M]) & (sum[M] != op_a[M]) :
               op == 4'b0110 ? (op_a[M] != op_b[M]) & (sum[M] != op_a[M]) : 1'b0;
  assign cry = (add_op | sub_op) & sum[XLEN];
  assign alu_res = op == 4'b0000 ? op_a & op_b :
                   op == 4'b0001 ? op_a | op_b :
                   op == 4'b1100 ? ~(op_a | op_b) :
                   op == 4'b0111 ? {{M{1'b0}}, slt} : sum[M:0];
  assign zr = alu_res == '0;
  // signed greater-than: non-negative true difference and not equal
  assign cond = opcode[1] ? (alu_res[M] ~^ ovf) & !zr : opcode[0] ? !zr : zr;
`ifdef EX_MULDIV_EN
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] mul_acc, mul_a, mul_b, h_sd;
  logic [CW-1:0] cnt;
  logic [REGW-1:0] h_rd;
  logic h_rw, h_mtr, h_mw;
  assign start_mul = accept & op == 4'b1000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == IDLE) state_n = start_mul ? MUL : IDLE;
    else if (state == MUL) state_n = cnt == CW'(XLEN-1) ? DONE : MUL;
    else state_n = adv ? IDLE : DONE;
  end
  always_comb begin
    idle = state == IDLE;
    busy = state == MUL;
    wr_mul = state == DONE & adv;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mul_acc <= '0; mul_a <= '0; mul_b <= '0; cnt <= '0; h_sd <= '0;
      h_rd <= '0; h_rw <= 1'b0; h_mtr <= 1'b0; h_mw <= 1'b0;
    end else if (start_mul) begin
      mul_acc <= '0; mul_a <= op_a; mul_b <= op_b; cnt <= '0; h_sd <= rt_val;
      h_rd <= rd; h_rw <= reg_write; h_mtr <= mem_to_reg; h_mw <= mem_write;
    end else if (state == MUL) begin
      mul_acc <= mul_acc + (mul_b[0] ? mul_a : '0);
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt <= cnt + 1'b1;
    end
  assign w_res = wr_mul ? mul_acc : alu_res;
  assign w_sd = wr_mul ? h_sd : rt_val;
  assign w_rd = wr_mul ? h_rd : rd;
  assign w_rw = wr_mul ? h_rw : reg_write;
  assign w_mtr = wr_mul ? h_mtr : mem_to_reg;
  assign w_mw = wr_mul ? h_mw : mem_write;
`else
  assign start_mul = 1'b0;
  assign idle = 1'b1;
  assign busy = 1'b0;
  assign wr_mul = 1'b0;
  assign w_res = alu_res;
  assign w_sd = rt_val;
  assign w_rd = rd;
  assign w_rw = reg_write;
  assign w_mtr = mem_to_reg;
  assign w_mw = mem_write;
`endif
  assign wr_alu = accept & !start_mul;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0; result <= '0; store_data <= '0; rd_o <= '0;
      reg_write_o <= 1'b0; mem_to_reg_o <= 1'b0; mem_write_o <= 1'b0;
      branch_taken <= 1'b0; zero <= 1'b0; carry <= 1'b0; overflow <= 1'b0; set <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      branch_taken <= 1'b0;
    end else if (adv) begin
      out_valid <= wr_alu | wr_mul;
      branch_taken <= wr_alu & branch & cond;
      if (wr_alu | wr_mul) begin
        result <= w_res; store_data <= w_sd; rd_o <= w_rd;
        reg_write_o <= w_rw; mem_to_reg_o <= w_mtr; mem_write_o <= w_mw;
        zero <= w_res == '0;
        carry <= !wr_mul & cry;
        overflow <= !wr_mul & ovf;
        set <= !wr_mul & op == 4'b0111 & slt;
      end
    end
endmodule

// File: tb/tb_ex_stage_hs.sv
// tb_ex_stage_hs: directed table-driven check of ex_stage_hs plus hazard/backpressure sequences
module tb_ex_stage_hs;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [3:0] op;
  logic [5:0] opcode;
  logic [31:0] a, b, mem_fwd_data, result, store_data;
  logic [15:0] imm;
  logic [4:0] rs, rt, rd, mem_rd, rd_o;
  logic [1:0] alusrc;
  logic reg_write, mem_to_reg, mem_write, branch, mem_rd_we;
  logic reg_write_o, mem_to_reg_o, mem_write_o, branch_taken, zero, carry, overflow, set, load_stall, busy;
  int tests = 0, fails = 0;

  ex_stage_hs #(.XLEN(32), .REGW(5), .IMMW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .opcode(opcode),
    .a(a), .b(b), .imm(imm), .rs(rs), .rt(rt), .rd(rd), .alusrc(alusrc), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch), .mem_rd(mem_rd),
    .mem_rd_we(mem_rd_we), .mem_fwd_data(mem_fwd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .store_data(store_data), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .mem_write_o(mem_write_o),
    .branch_taken(branch_taken), .zero(zero), .carry(carry), .overflow(overflow), .set(set),
    .load_stall(load_stall), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [5:0] opcode; logic [31:0] a, b; logic [15:0] imm;
    logic [1:0] alusrc; logic br; logic [31:0] res; logic [4:0] flags;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    in_valid = 0; op = 0; opcode = 0; a = 0; b = 0; imm = 0; rs = 0; rt = 0; rd = 0; alusrc = 0;
    reg_write = 0; mem_to_reg = 0; mem_write = 0; branch = 0; mem_rd = 0; mem_rd_we = 0;
    mem_fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic rw, input logic mtr);
    in_valid = 1; op = o; a = va; b = vb; rs = s; rt = t; rd = d; reg_write = rw; mem_to_reg = mtr;
    alusrc = 0; imm = 0; branch = 0; opcode = 0;
  endtask

  initial begin
    // flags = {zero, carry, overflow, set, branch_taken}
    v.push_back('{4'b0010, 6'd0, 32'd7, 32'd5, 16'd0, 2'b00, 1'b0, 32'd12, 5'b00000});
    v.push_back('{4'b0110, 6'b000100, 32'd5, 32'd5, 16'd0, 2'b00, 1'b1, 32'd0, 5'b11001});
    v.push_back('{4'b0000, 6'd0, 32'h0000F0F0, 32'h0000FF00, 16'd0, 2'b00, 1'b0, 32'h0000F000, 5'b00000});
    v.push_back('{4'b0001, 6'd0, 32'h0000F0F0, 32'h00000F0F, 16'd0, 2'b00, 1'b0, 32'h0000FFFF, 5'b00000});
    v.push_back('{4'b1100, 6'd0, 32'd0, 32'd0, 16'd0, 2'b00, 1'b0, 32'hFFFFFFFF, 5'b00000});
    v.push_back('{4'b0111, 6'd0, 32'hFFFFFFFF, 32'd1, 16'd0, 2'b00, 1'b0, 32'd1, 5'b01010});
    v.push_back('{4'b0010, 6'd0, 32'h7FFFFFFF, 32'd1, 16'd0, 2'b00, 1'b0, 32'h80000000, 5'b00100});
    v.push_back('{4'b0010, 6'd0, 32'hFFFFFFFF, 32'd1, 16'd0, 2'b00, 1'b0, 32'd0, 5'b11000});
    v.push_back('{4'b0010, 6'd0, 32'd10, 32'd0, 16'hFFFF, 2'b01, 1'b0, 32'd9, 5'b01000});
    v.push_back('{4'b0001, 6'd0, 32'd0, 32'd0, 16'h8001, 2'b10, 1'b0, 32'h00008001, 5'b00000});
    v.push_back('{4'b0001, 6'd0, 32'h12, 32'd0, 16'hABCD, 2'b11, 1'b0, 32'hABCD0012, 5'b00000});
    v.push_back('{4'b0110, 6'b000101, 32'd3, 32'd3, 16'd0, 2'b00, 1'b1, 32'd0, 5'b11000});
    v.push_back('{4'b0110, 6'b000010, 32'd5, 32'd3, 16'd0, 2'b00, 1'b1, 32'd2, 5'b01001});
    v.push_back('{4'b0110, 6'b000010, 32'd3, 32'd5, 16'd0, 2'b00, 1'b1, 32'hFFFFFFFE, 5'b00000});
    v.push_back('{4'b0110, 6'b000011, 32'h7FFFFFFF, 32'hFFFFFFFF, 16'd0, 2'b00, 1'b1, 32'h80000000, 5'b00101});
    v.push_back('{4'b0010, 6'b000001, 32'd1, 32'd1, 16'd0, 2'b00, 1'b1, 32'd2, 5'b00001});
`ifndef EX_MULDIV_EN
    v.push_back('{4'b1000, 6'd0, 32'd4, 32'd6, 16'd0, 2'b00, 1'b0, 32'd10, 5'b00000});
`endif
    clr();
    in_valid = 1;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_outs", {out_valid, result, branch_taken, zero, carry, overflow, set, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    in_valid = 0;
    #1;
    chk("release_in_ready", in_ready, 1);
    step();
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].a, v[i].b, 0, 0, 0, 1, 0);
      opcode = v[i].opcode; imm = v[i].imm; alusrc = v[i].alusrc; branch = v[i].br;
      step();
      chk($sformatf("vec%0d_result", i), result, v[i].res);
      chk($sformatf("vec%0d_flags", i), {zero, carry, overflow, set, branch_taken}, v[i].flags);
      chk($sformatf("vec%0d_valid_sd", i), {out_valid, store_data}, {1'b1, v[i].b});
    end
    clr();
    step();
    chk("bubble_valid", {out_valid, branch_taken}, 0);
    issue(4'b0010, 1, 2, 0, 0, 3, 1, 0);
    step();
    chk("fwd_first", result, 3);
    issue(4'b0110, 100, 1, 3, 0, 0, 0, 0);
    mem_rd = 3; mem_rd_we = 1; mem_fwd_data = 50;
    step();
    chk("fwd_ex_wins", result, 2);
    issue(4'b0010, 0, 1, 7, 0, 0, 0, 0);
    mem_rd = 7; mem_fwd_data = 20;
    step();
    chk("fwd_mem", result, 21);
    mem_rd_we = 0;
    issue(4'b0010, 3, 4, 0, 0, 6, 1, 0);
    step();
    issue(4'b0001, 0, 0, 0, 6, 0, 0, 0);
    step();
    chk("fwd_rt", {result, store_data}, {32'd7, 32'd7});
    issue(4'b0010, 0, 0, 0, 0, 4, 1, 1);
    step();
    issue(4'b0010, 0, 1, 4, 0, 0, 0, 0);
    #1;
    chk("ldu_stall", {load_stall, in_ready}, 2'b10);
    step();
    chk("ldu_bubble", out_valid, 0);
    mem_rd = 4; mem_rd_we = 1; mem_fwd_data = 9;
    #1;
    chk("ldu_clear", {load_stall, in_ready}, 2'b01);
    step();
    chk("ldu_result", {out_valid, result}, {1'b1, 32'd10});
    clr();
    issue(4'b0010, 7, 5, 0, 0, 0, 1, 0);
    step();
    out_ready = 0;
    issue(4'b0010, 1, 1, 0, 0, 0, 1, 0);
    #1;
    chk("bp_in_ready", in_ready, 0);
    step();
    chk("bp_hold1", {out_valid, result}, {1'b1, 32'd12});
    flush = 1;
    #1;
    chk("bp_hold_pre_flush", {out_valid, result}, {1'b1, 32'd12});
    step();
    chk("bp_flush", {out_valid, branch_taken}, 0);
    flush = 0;
    step();
    chk("bp_after", {out_valid, result}, {1'b1, 32'd2});
    out_ready = 1;
`ifdef EX_MULDIV_EN
    begin
      int cnt = 0;
      issue(4'b1000, 32'hFFFFFFFF, 3, 0, 0, 5, 1, 0);
      step();
      in_valid = 0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
        if (busy) cnt++;
        step();
      end
      chk("mul_busy_cycles", cnt, 32);
      chk("mul_result", {out_valid, result, zero, carry, overflow}, {1'b1, 32'hFFFFFFFD, 3'b000});
      issue(4'b1000, 5, 5, 0, 0, 5, 1, 0);
      step();
      in_valid = 0;
      repeat (5) step();
      flush = 1;
      step();
      flush = 0;
      chk("mul_flush_busy", busy, 0);
      cnt = 0;
      repeat (40) begin
        if (out_valid) cnt++;
        step();
      end
      chk("mul_flush_no_out", cnt, 0);
    end
`endif
    issue(4'b0010, 2, 2, 0, 0, 0, 1, 0);
    step();
    rst_n = 0;
    #1;
    chk("async_reset", {out_valid, result, in_ready, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
